// File: rtl/mc_merge_fifo_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_merge_fifo_if : producer/reader bundle for the multi-channel merge FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
interface mc_merge_fifo_if #(
   parameter int NUM_CH = 9,
   parameter int DATA_W = 9,
   parameter int DEPTH  = 16
) ();
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_CH-1:0]        wen;
   logic [NUM_CH*DATA_W-1:0] i_data;
   logic                     ren;
   logic                     clr_ovf;
   logic                     valid;
   logic [DATA_W-1:0]        o_data;
   logic [CH_W-1:0]          o_chan;
   logic                     freeze_clk;
   logic [CNT_W-1:0]         count;
   logic [NUM_CH-1:0]        overflow;

   modport master (
      output wen, i_data, ren, clr_ovf,
      input  valid, o_data, o_chan, freeze_clk, count, overflow
   );

   modport slave (
      input  wen, i_data, ren, clr_ovf,
      output valid, o_data, o_chan, freeze_clk, count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/mc_merge_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_merge_fifo : per-channel pending slots, round-robin merge into tagged FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_merge_fifo #(
   parameter int NUM_CH = 9,
   parameter int DATA_W = 9,
   parameter int DEPTH  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   mc_merge_fifo_if.slave  bus
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = CH_W + DATA_W;

   logic [DATA_W-1:0] wr_data [NUM_CH];

   logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
   logic [DATA_W-1:0] pend_data_q [NUM_CH];
   logic [NUM_CH-1:0] accept, drop;

   logic              gnt_any;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   rr_q, rr_d;

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;

   logic              valid_q;
   logic [DATA_W-1:0] o_data_q;
   logic [CH_W-1:0]   o_chan_q;
   logic              freeze_q, freeze_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign wr_data[gi] = bus.i_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search from rr; no grant at all while the FIFO is full.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (count_q < CNT_W'(DEPTH)) begin
         for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NUM_CH) begin
               idx = idx - NUM_CH;
            end
            if (!gnt_any && pend_vld_q[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = CH_W'(idx);
            end
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_any) begin
         rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
   end

   // A slot being granted this cycle frees up in time to take a new word.
   always_comb begin
      accept     = '0;
      drop       = '0;
      pend_vld_d = pend_vld_q;
      for (int i = 0; i < NUM_CH; i++) begin
         logic granted;
         granted       = gnt_any && (gnt_idx == CH_W'(i));
         accept[i]     = bus.wen[i] && (!pend_vld_q[i] || granted);
         drop[i]       = bus.wen[i] && pend_vld_q[i] && !granted;
         pend_vld_d[i] = accept[i] || (pend_vld_q[i] && !granted);
      end
   end

   // A drop in the same cycle as clr_ovf keeps its flag.
   always_comb begin
      ovf_d = (bus.clr_ovf ? '0 : ovf_q) | drop;
   end

   assign push = gnt_any;
   assign pop  = bus.ren && (count_q != '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      freeze_d = (|pend_vld_d) || (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_vld_q <= '0;
         rr_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         o_data_q   <= '0;
         o_chan_q   <= '0;
         freeze_q   <= 1'b0;
         ovf_q      <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         rr_q       <= rr_d;
         count_q    <= count_d;
         freeze_q   <= freeze_d;
         ovf_q      <= ovf_d;
         valid_q    <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
            {o_chan_q, o_data_q}  <= mem_q[rd_ptr_q];
         end
      end
   end

   // Storage only; occupancy is governed by the valid bits and count above.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (accept[i]) begin
            pend_data_q[i] <= wr_data[i];
         end
      end
      if (push) begin
         mem_q[wr_ptr_q] <= {gnt_idx, pend_data_q[gnt_idx]};
      end
   end

   assign bus.valid      = valid_q;
   assign bus.o_data     = o_data_q;
   assign bus.o_chan     = o_chan_q;
   assign bus.freeze_clk = freeze_q;
   assign bus.count      = count_q;
   assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_merge_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mc_merge_fifo : directed scoreboard bench for mc_merge_fifo
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mc_merge_fifo;
   localparam int NUM_CH = 9;
   localparam int DATA_W = 9;
   localparam int DEPTH  = 16;
   localparam int CH_W   = 4;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   mc_merge_fifo_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   mc_merge_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [CH_W+DATA_W-1:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
      bus.i_data[ch*DATA_W +: DATA_W] = v;
   endtask

   function automatic void exp_push(input int ch, input int d);
      sb.push_back({CH_W'(ch), DATA_W'(d)});
   endfunction

   task automatic read_one(input string tag);
      logic [CH_W+DATA_W-1:0] e;
      bus.ren = 1'b1;
      @(negedge clk);
      bus.ren = 1'b0;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed valid=%0b expected no read", tag, bus.valid);
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
         chk({tag, "_data"}, 32'(bus.o_data), 32'(e[DATA_W-1:0]));
         chk({tag, "_chan"}, 32'(bus.o_chan), 32'(e[CH_W+DATA_W-1:DATA_W]));
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.wen     = '0;
      bus.i_data  = '0;
      bus.ren     = 1'b0;
      bus.clr_ovf = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_data", 32'(bus.o_data), 32'd0);
      chk("rst_chan", 32'(bus.o_chan), 32'd0);
      chk("rst_freeze", 32'(bus.freeze_clk), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // read on empty FIFO
      bus.ren = 1'b1;
      @(negedge clk);
      bus.ren = 1'b0;
      chk("empty_valid", 32'(bus.valid), 32'd0);
      chk("empty_count", 32'(bus.count), 32'd0);

      // single write on channel 2
      set_data(2, 9'h1A5);
      bus.wen = 9'b000000100;
      exp_push(2, 'h1A5);
      @(negedge clk);
      bus.wen = '0;
      chk("single_freeze_on", 32'(bus.freeze_clk), 32'd1);
      chk("single_count0", 32'(bus.count), 32'd0);
      @(negedge clk);
      chk("single_freeze_off", 32'(bus.freeze_clk), 32'd0);
      chk("single_count1", 32'(bus.count), 32'd1);
      read_one("single");
      chk("single_count_after", 32'(bus.count), 32'd0);
      @(negedge clk);
      chk("single_pulse", 32'(bus.valid), 32'd0);
      chk("single_hold", 32'(bus.o_data), 32'h1A5);

      // channel 8 alone, leaving rr at 0
      set_data(8, 9'h055);
      bus.wen = 9'h100;
      exp_push(8, 'h055);
      @(negedge clk);
      bus.wen = '0;
      @(negedge clk);
      read_one("ch8");

      // all channels at once, rr = 0
      for (int i = 0; i < NUM_CH; i++) begin
         set_data(i, DATA_W'(i + 1));
         exp_push(i, i + 1);
      end
      bus.wen = '1;
      for (int c = 0; c < NUM_CH; c++) begin
         @(negedge clk);
         bus.wen = '0;
         chk($sformatf("all_freeze%0d", c), 32'(bus.freeze_clk), 32'd1);
      end
      @(negedge clk);
      chk("all_freeze_off", 32'(bus.freeze_clk), 32'd0);
      chk("all_count", 32'(bus.count), 32'd9);
      for (int i = 0; i < NUM_CH; i++) read_one($sformatf("all%0d", i));

      // ch3+ch1 with rr = 0: ch1 granted first
      set_data(3, 9'h033);
      set_data(1, 9'h011);
      bus.wen = 9'b000001010;
      exp_push(1, 'h011);
      exp_push(3, 'h033);
      @(negedge clk);
      bus.wen = '0;
      repeat (2) @(negedge clk);
      chk("rr0_count", 32'(bus.count), 32'd2);
      read_one("rr0_a");
      read_one("rr0_b");

      // ch1 alone moves rr to 2
      set_data(1, 9'h0E1);
      bus.wen = 9'b000000010;
      exp_push(1, 'h0E1);
      @(negedge clk);
      bus.wen = '0;
      @(negedge clk);
      read_one("rr_set");

      // ch3+ch1 with rr = 2: ch3 granted first
      set_data(3, 9'h133);
      set_data(1, 9'h111);
      bus.wen = 9'b000001010;
      exp_push(3, 'h133);
      exp_push(1, 'h111);
      @(negedge clk);
      bus.wen = '0;
      repeat (2) @(negedge clk);
      read_one("rr2_a");
      read_one("rr2_b");

      // fill to DEPTH through channel 0, one word per cycle
      for (int i = 0; i < DEPTH; i++) begin
         set_data(0, DATA_W'(9'h100 + i));
         bus.wen = 9'h001;
         exp_push(0, 'h100 + i);
         @(negedge clk);
      end
      bus.wen = '0;
      @(negedge clk);
      chk("full_count", 32'(bus.count), 32'd16);
      chk("full_freeze", 32'(bus.freeze_clk), 32'd1);
      set_data(0, 9'h0AA);
      bus.wen = 9'h001;
      exp_push(0, 'h0AA);
      @(negedge clk);
      bus.wen = '0;
      chk("full_hold_count", 32'(bus.count), 32'd16);
      chk("full_hold_freeze", 32'(bus.freeze_clk), 32'd1);
      @(negedge clk);
      chk("full_hold_count2", 32'(bus.count), 32'd16);
      read_one("full_pop0");
      chk("full_pop_count", 32'(bus.count), 32'd15);
      chk("full_pop_freeze", 32'(bus.freeze_clk), 32'd1);
      @(negedge clk);
      chk("full_regrant_count", 32'(bus.count), 32'd16);
      chk("full_regrant_freeze", 32'(bus.freeze_clk), 32'd1);
      read_one("full_pop1");
      chk("full_release_count", 32'(bus.count), 32'd15);
      chk("full_release_freeze", 32'(bus.freeze_clk), 32'd0);
      while (sb.size() > 0) read_one("full_drain");
      chk("full_empty", 32'(bus.count), 32'd0);

      // overflow on ch5 while ch0..4 are pending (rr = 1)
      for (int i = 0; i < 5; i++) set_data(i, DATA_W'(9'h0C0 + i));
      set_data(5, 9'h0B5);
      bus.wen = 9'h03F;
      for (int i = 1; i < 5; i++) exp_push(i, 'h0C0 + i);
      exp_push(5, 'h0B5);
      exp_push(0, 'h0C0);
      @(negedge clk);
      set_data(5, 9'h0B6);
      bus.wen = 9'h020;
      @(negedge clk);
      bus.wen = '0;
      chk("ovf_set", 32'(bus.overflow), 32'h020);
      repeat (6) @(negedge clk);
      chk("ovf_count", 32'(bus.count), 32'd6);
      for (int i = 0; i < 6; i++) read_one($sformatf("ovf%0d", i));
      chk("ovf_sticky", 32'(bus.overflow), 32'h020);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      chk("ovf_clr", 32'(bus.overflow), 32'h000);

      // new ch5 overflow coinciding with clr_ovf
      for (int i = 0; i < 5; i++) set_data(i, DATA_W'(9'h0D0 + i));
      set_data(5, 9'h0D5);
      bus.wen = 9'h03F;
      for (int i = 1; i < 5; i++) exp_push(i, 'h0D0 + i);
      exp_push(5, 'h0D5);
      exp_push(0, 'h0D0);
      @(negedge clk);
      set_data(5, 9'h0D6);
      bus.wen = 9'h020;
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.wen = '0;
      bus.clr_ovf = 1'b0;
      chk("ovf_set_wins", 32'(bus.overflow), 32'h020);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 6; i++) read_one($sformatf("ovf2_%0d", i));

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < NUM_CH; i++) set_data(i, DATA_W'(9'h040 + i));
      bus.wen = '1;
      @(negedge clk);
      bus.wen = '0;
      repeat (3) @(negedge clk);
      chk("mid_count", 32'(bus.count), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.valid), 32'd0);
      chk("arst_data", 32'(bus.o_data), 32'd0);
      chk("arst_chan", 32'(bus.o_chan), 32'd0);
      chk("arst_freeze", 32'(bus.freeze_clk), 32'd0);
      chk("arst_count", 32'(bus.count), 32'd0);
      chk("arst_ovf", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      sb.delete();
      @(negedge clk);
      bus.ren = 1'b1;
      @(negedge clk);
      bus.ren = 1'b0;
      chk("post_rst_valid", 32'(bus.valid), 32'd0);
      chk("post_rst_count", 32'(bus.count), 32'd0);
      chk("post_rst_freeze", 32'(bus.freeze_clk), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
